axi_stream_rr_arbiter: RTL and testbench
========================================

# axi_stream_rr_arbiter

- Shares the single outbound AXI-stream channel between `NUM_SRC` encryption/authentication sources.
- Arbitration is round-robin and packet-locked: once a source wins, it keeps the channel until its `last` beat is accepted.
- Output is registered, so the block sits directly in front of `axi_stream_master` and drives its `valid_input`/`data_in`/`ready_sys` side.

## Interface
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `DATA_WIDTH`, 512: beat width in bits.
- `ID_WIDTH`, $clog2(NUM_SRC): width of the source index.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_valid`  in  NUM_SRC  per-source beat valid.
- `src_data`  in  NUM_SRC*DATA_WIDTH  per-source beat; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_last`  in  NUM_SRC  per-source end-of-packet marker.
- `src_ready`  out  NUM_SRC  per-source accept, one-hot or zero.
- `ready_sys`  in  1  downstream ready.
- `valid`  out  1  output beat valid (registered).
- `data_out`  out  DATA_WIDTH  output beat (registered).
- `last_out`  out  1  output end-of-packet (registered).
- `src_id`  out  ID_WIDTH  index of the source that produced the current output beat (registered).

## Operation
- Output holding register (`valid`, `data_out`, `last_out`, `src_id`):
  - `load_en = !valid || ready_sys`.
  - Source i transfers when `src_valid[i] && src_ready[i]`.
- Internal state:
  - `locked` (1 bit).
  - `grant` (ID_WIDTH): the locked source, or the last winner when unlocked.
- Selection when unlocked (combinational):
  - Search indices grant+1, grant+2, … modulo NUM_SRC, and pick the first i with `src_valid[i]`.
  - If none is valid, nothing is selected.
- Selection when locked:
  - Select `grant` only.
  - Other sources are never readied, whatever their valid.
- `src_ready[sel] = load_en` for the selected source; all other bits are 0.
  - `src_ready` does not depend on `src_valid` of the same source beyond selection.
- On a transfer from source i:
  - The holding register loads `src_data[i]`, `src_last[i]`, and i; `valid` is set to 1.
  - `grant <= i`.
  - `locked <= !src_last[i]`.
- When `load_en` is set but no source transfers, `valid <= 0` and the data fields hold their value.
- A single-beat packet (`last=1` on the first beat) never locks.
- While locked and the granted source deasserts valid mid-packet:
  - The channel stays locked and idles (`valid` drops after drain).
  - No other source is served.
- The block does not check packet lengths.
- Reset (asynchronous, immediate):
  - `valid=0`, `data_out=0`, `last_out=0`, `src_id=0`, `src_ready=0`, `locked=0`.
  - `grant=NUM_SRC-1`, so source 0 has first priority.
- Reset mid-packet discards the held beat and the lock, with no flush.
- Once reset deasserts, arbitration restarts on the first rising edge.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `valid`/`data_out` after edge N.
- Throughput is one beat per cycle while `ready_sys=1` and the selected source streams continuously.
- Backpressure with `valid=1 && ready_sys=0`:
  - All `src_ready` are 0.
  - The output is held stable, and `data_out`/`last_out`/`src_id` must not change.
- Simultaneous downstream accept and upstream load in one cycle is allowed; there is no bubble.
- Arbitration decision and `src_ready` are combinational in the same cycle as `src_valid`.
- The grant pointer updates at the transfer edge.
- A released source (last accepted at edge N) can win again at edge N+1 only if no other source is valid.
- Pointer wrap: after source NUM_SRC-1 wins, the search starts at source 0.
- `ready_sys` low for any number of cycles loses no beat and duplicates none.

## Test plan
- **Reset:** assert `reset` mid-stream with `valid=1` → `valid`, `src_ready`, `data_out` go to 0 immediately. After release with all 4 sources valid, single-beat `last=1` → first beat is from src 0.
- **Fairness:** all 4 sources hold valid with single-beat packets, `ready_sys=1` →
  - `src_id` sequence is 0,1,2,3,0,1,…
  - One beat per cycle, with data values `'hA5A5A5A5A5A5A5A5`+i matching source i.
- **Packet lock:** src 1 sends 3 beats (last on beat 3) while src 2 and src 3 are valid → `src_id` is 1,1,1,2,3. `src_ready[2]` stays 0 until src 1's beat 3 transfers.
- **Backpressure:** `ready_sys=0` for 5 cycles with `valid=1` and `data_out='h1234567890ABCDEF` →
  - Output is stable and all `src_ready` are 0.
  - On `ready_sys=1` the next beat follows in the same cycle-edge, with no gap.
- **Idle/holes:** only src 3 is valid, then src 3 deasserts valid mid-packet for 2 cycles while src 0 is valid →
  - `valid` drops after the drain and src 0 is not served.
  - src 3 resumes; after its last beat, src 0 is granted next.
- **Wrap:** pointer at src 3, then src 0 and src 2 both valid → src 0 wins first, then src 2.

Source files
------------

// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin, packet-locked arbiter that merges NUM_SRC AXI-stream sources
// into one registered output channel.
module axi_stream_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          ready_sys,
  output logic                          valid,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          last_out,
  output logic [ID_WIDTH-1:0]           src_id
);

  logic                  locked_reg;
  logic [ID_WIDTH-1:0]   grant_reg;
  logic                  load_en;
  logic                  sel_found;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   sel_idx;
  logic [ID_WIDTH:0]     cand;
  logic [DATA_WIDTH-1:0] src_beat [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_beat[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign load_en = !valid || ready_sys;

  // Walk downwards so the nearest valid index after the pointer is written last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_reg;
    cand      = '0;
    if (locked_reg) begin
      sel_found = 1'b1;
    end else begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        cand = {1'b0, grant_reg} + (ID_WIDTH+1)'(k);
        if (cand >= (ID_WIDTH+1)'(NUM_SRC))
          cand = cand - (ID_WIDTH+1)'(NUM_SRC);
        if (src_valid[cand[ID_WIDTH-1:0]]) begin
          sel_found = 1'b1;
          sel_idx   = cand[ID_WIDTH-1:0];
        end
      end
    end
  end

  assign xfer = load_en && sel_found && src_valid[sel_idx];

  // Gated by reset so no source sees an accept while the block is held in reset.
  always_comb begin
    src_ready = '0;
    if (!reset && sel_found && load_en)
      src_ready[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      data_out   <= '0;
      last_out   <= 1'b0;
      src_id     <= '0;
      locked_reg <= 1'b0;
      grant_reg  <= ID_WIDTH'(NUM_SRC - 1);
    end else if (xfer) begin
      valid      <= 1'b1;
      data_out   <= src_beat[sel_idx];
      last_out   <= src_last[sel_idx];
      src_id     <= sel_idx;
      grant_reg  <= sel_idx;
      locked_reg <= !src_last[sel_idx];
    end else if (load_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Bench for axi_stream_rr_arbiter: random traffic against a queue-free
// behavioural model, plus directed scenarios with literal expectations.
module tb_axi_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_valid, src_last, src_ready;
  logic [N*DW-1:0] src_data;
  logic            ready_sys, valid, last_out;
  logic [DW-1:0]   data_out;
  logic [IW-1:0]   src_id;

  int checks   = 0;
  int failures = 0;

  axi_stream_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .ready_sys(ready_sys),
    .valid(valid), .data_out(data_out), .last_out(last_out), .src_id(src_id)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: owner = locked source or last winner.
  logic          m_valid, m_last, m_locked;
  logic [DW-1:0] m_data;
  int            m_id, m_owner;

  function automatic int pick();
    int i;
    if (m_locked) return m_owner;
    for (int k = 1; k <= N; k++) begin
      i = (m_owner + k) % N;
      if (src_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int s;
    logic [N-1:0] r;
    r = '0;
    s = pick();
    if (!reset && (!m_valid || ready_sys) && s >= 0) r[s] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_data <= '0; m_last <= 1'b0; m_id <= 0;
      m_locked <= 1'b0; m_owner <= N - 1;
    end else if ((!m_valid || ready_sys) && pick() >= 0 && src_valid[pick()]) begin
      m_valid  <= 1'b1;
      m_data   <= src_data[pick()*DW +: DW];
      m_last   <= src_last[pick()];
      m_id     <= pick();
      m_owner  <= pick();
      m_locked <= !src_last[pick()];
    end else if (!m_valid || ready_sys) begin
      m_valid <= 1'b0;
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready", src_ready, model_ready());
    check("valid", valid, m_valid);
    check("data", data_out, m_data);
    check("last", last_out, m_last);
    check("id", src_id, m_id[IW-1:0]);
  end

  logic [N-1:0] xfer, ready_seen;

  task automatic tick();
    @(negedge clk);
    xfer       = src_valid & src_ready;
    ready_seen = src_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(int i, bit v, bit l, logic [DW-1:0] d);
    src_valid[i] = v;
    src_last[i]  = l;
    src_data[i*DW +: DW] = d;
  endtask

  logic [31:0]   seq [N];
  logic [DW-1:0] d;
  int            lock_exp [5] = '{1, 1, 1, 2, 3};
  int            b1;

  initial begin
    reset = 1'b0; ready_sys = 1'b0;
    src_valid = '0; src_last = '0; src_data = '0;
    xfer = '0; ready_seen = '0;
    #1 reset = 1'b1;
    src_valid = '1;
    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_id", src_id, 0);
    check("rst_ready", ready_seen, 0);
    src_valid = '0;
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (xfer[i]) seq[i]++;
        d = '0;
        d[63:0] = {32'(i), seq[i]};
        set_src(i, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, d);
      end
      ready_sys = $urandom_range(0, 9) < 7;
      tick();
    end

    // Mid-stream reset
    ready_sys = 1'b1;
    src_valid = '1;
    tick(); tick();
    check("pre_rst_valid", valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_data", data_out, 0);
    check("async_rst_ready", src_ready, 0);
    tick();
    reset = 1'b0;

    // Fairness: four single-beat streams
    for (int i = 0; i < N; i++) set_src(i, 1, 1, 64'hA5A5A5A5A5A5A5A5 + 64'(i));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fair_ready", ready_seen, 1 << (k % 4));
      check("fair_id", src_id, k % 4);
      check("fair_data", data_out, 64'hA5A5A5A5A5A5A5A5 + 64'(k % 4));
      check("fair_valid", valid, 1);
    end
    src_valid = '0;
    tick();
    check("fair_drain", valid, 0);

    // Packet lock: src 1 sends 3 beats while 2 and 3 wait
    b1 = 0;
    set_src(1, 1, 0, 'h100);
    set_src(2, 1, 1, 'h200);
    set_src(3, 1, 1, 'h300);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("lock_ready", ready_seen, 1 << lock_exp[k]);
      check("lock_id", src_id, lock_exp[k]);
      if (xfer[1]) b1++;
      set_src(1, b1 < 3, b1 == 2, 'h100 + DW'(b1));
      if (xfer[2]) src_valid[2] = 1'b0;
      if (xfer[3]) src_valid[3] = 1'b0;
    end
    src_valid = '0;
    tick();

    // Backpressure
    set_src(0, 1, 1, 64'h1234567890ABCDEF);
    tick();
    check("bp_load", data_out, 64'h1234567890ABCDEF);
    set_src(0, 1, 1, 'hCAFE);
    ready_sys = 1'b0;
    repeat (5) begin
      tick();
      check("bp_ready", ready_seen, 0);
      check("bp_valid", valid, 1);
      check("bp_data", data_out, 64'h1234567890ABCDEF);
      check("bp_id", src_id, 0);
    end
    ready_sys = 1'b1;
    tick();
    check("bp_resume_ready", ready_seen, 4'b0001);
    check("bp_resume_data", data_out, 'hCAFE);
    src_valid = '0;
    tick();

    // Holes: src 3 pauses mid-packet, src 0 must wait
    set_src(3, 1, 0, 'h3000);
    tick();
    check("hole_id0", src_id, 3);
    set_src(3, 0, 0, 'h3001);
    set_src(0, 1, 1, 'h0A);
    repeat (2) begin
      tick();
      check("hole_ready", ready_seen, 4'b1000);
      check("hole_valid", valid, 0);
    end
    set_src(3, 1, 0, 'h3001);
    tick();
    check("hole_data1", data_out, 'h3001);
    set_src(3, 1, 1, 'h3002);
    tick();
    check("hole_last", last_out, 1);
    check("hole_id2", src_id, 3);
    src_valid[3] = 1'b0;
    tick();
    check("hole_next_id", src_id, 0);
    check("hole_next_data", data_out, 'h0A);
    src_valid = '0;
    tick();

    // Wrap: pointer at 3, then 0 and 2 compete
    set_src(3, 1, 1, 'h33);
    tick();
    check("wrap_id3", src_id, 3);
    src_valid[3] = 1'b0;
    set_src(0, 1, 1, 'h50);
    set_src(2, 1, 1, 'h52);
    tick();
    check("wrap_first", src_id, 0);
    src_valid[0] = 1'b0;
    tick();
    check("wrap_second", src_id, 2);
    src_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
